// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, bit timing, frame length and the
// arbiter FSM state encoding.
package uart_pkg;

   localparam int UART_BYTE_W  = 8;
   localparam int CLKS_PER_BIT = 8;
   localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_GAP       = 3'd3,
      ST_HOLD      = 3'd4
   } arb_state_e;

   // Pick byte lane idx out of a flattened requester data bus (up to 8 lanes).
   function automatic logic [UART_BYTE_W-1:0] byte_lane(input logic [63:0] bus,
                                                        input logic [2:0]  idx);
      return bus[{idx, 3'b000} +: UART_BYTE_W];
   endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Combinational round-robin selector: first set request strictly after the
// previous winner, wrapping around; returns one-hot and encoded winner.
module rr_priority_sel #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] last,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx
);

   logic         found_s;
   logic         hit_s;
   logic [W-1:0] slot_s;

   // Scan N slots starting one past the previous winner; first hit wins.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      found_s = 1'b0;
      hit_s   = 1'b0;
      slot_s  = '0;
      for (int k = 1; k <= N; k++) begin
         slot_s      = W'((int'(last) + k) % N);
         hit_s       = req[slot_s] & ~found_s;
         gnt[slot_s] = hit_s;
         idx         = hit_s ? slot_s : idx;
         found_s     = found_s | hit_s;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte streams,
// with an inter-frame idle gap and capped packet locking.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int NUM_REQ  = 4,
   parameter  int GAP_CLKS = 8,
   parameter  int MAX_PKT  = 16,
   localparam int IW       = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [8*NUM_REQ-1:0]     req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     tx_load,
   output logic [UART_BYTE_W-1:0]   tx_data,
   input  logic                     tx_done,
   output logic [IW-1:0]            grant_id,
   output logic                     locked,
   output logic                     busy
);

   localparam int             CW        = $clog2(MAX_PKT + 1);
   localparam int             GW        = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [GW-1:0]  GAP_LAST  = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(MAX_PKT);
   localparam logic [IW-1:0]  LAST_INIT = IW'(NUM_REQ - 1);
   localparam bit             NO_GAP    = (GAP_CLKS == 0);

   arb_state_e             state_r;
   logic [IW-1:0]          last_grant_r;
   logic [CW-1:0]          cnt_r;
   logic [GW-1:0]          gap_r;

   logic [NUM_REQ-1:0]     rr_gnt_s;
   logic [IW-1:0]          rr_idx_s;
   logic [IW-1:0]          sel_idx_s;
   logic [NUM_REQ-1:0]     hold_mask_s;
   logic                   accept_s;
   logic [CW-1:0]          cnt_next_s;
   logic [UART_BYTE_W-1:0] sel_byte_s;
   logic                   release_s;
   logic                   frame_end_s;

   rr_priority_sel #(
      .N   (NUM_REQ),
      .W   (IW)
   ) u_rr (
      .req (req_valid),
      .last(last_grant_r),
      .gnt (rr_gnt_s),
      .idx (rr_idx_s)
   );

   // Ready/select decode: round-robin in IDLE, owner-only in HOLD, none otherwise.
   always_comb begin
      hold_mask_s           = '0;
      hold_mask_s[grant_id] = 1'b1;
      case (state_r)
         ST_IDLE: begin
            req_ready = rr_gnt_s;
            sel_idx_s = rr_idx_s;
         end
         ST_HOLD: begin
            req_ready = hold_mask_s & req_valid;
            sel_idx_s = grant_id;
         end
         default: begin
            req_ready = '0;
            sel_idx_s = grant_id;
         end
      endcase
      accept_s    = |req_ready;
      cnt_next_s  = cnt_r + CW'(1);
      sel_byte_s  = byte_lane(64'(req_data), 3'(sel_idx_s));
      // The cap drops the lock even when the requester never flags last.
      release_s   = req_last[sel_idx_s] | (cnt_next_s == CNT_MAX);
      frame_end_s = ((state_r == ST_GAP) && (gap_r == GAP_LAST)) ||
                    ((state_r == ST_WAIT_DONE) && tx_done && NO_GAP);
   end

   // Arbiter FSM with registered load pulse, data latch and packet bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         tx_load      <= 1'b0;
         tx_data      <= '0;
         grant_id     <= '0;
         locked       <= 1'b0;
         last_grant_r <= LAST_INIT;
         cnt_r        <= '0;
         gap_r        <= '0;
      end else begin
         case (state_r)
            ST_IDLE, ST_HOLD: begin
               if (accept_s) begin
                  tx_data  <= sel_byte_s;
                  grant_id <= sel_idx_s;
                  locked   <= ~release_s;
                  cnt_r    <= cnt_next_s;
                  tx_load  <= 1'b1;
                  state_r  <= ST_LOAD;
               end else begin
                  state_r  <= state_r;
               end
            end
            ST_LOAD: begin
               tx_load <= 1'b0;
               state_r <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               gap_r <= '0;
               if (frame_end_s) begin
                  state_r <= locked ? ST_HOLD : ST_IDLE;
               end else if (tx_done) begin
                  state_r <= ST_GAP;
               end else begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            ST_GAP: begin
               gap_r <= gap_r + GW'(1);
               if (frame_end_s) begin
                  state_r <= locked ? ST_HOLD : ST_IDLE;
               end else begin
                  state_r <= ST_GAP;
               end
            end
            default: begin
               tx_load <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
         // Returning to IDLE closes the packet: advance pointer, restart count.
         if (frame_end_s && !locked) begin
            last_grant_r <= grant_id;
            cnt_r        <= '0;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench: byte queues per requester, a transaction-level
// arbitration model and a behavioural uart_tx that answers loads with done.
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N   = 4;
   localparam int G   = 8;
   localparam int M   = 16;
   localparam int IW  = 2;
   localparam int BIG = 1 << 30;

   logic clk = 1'b0;
   always #50 clk = ~clk;

   logic             rst;
   logic [N-1:0]     req_valid, req_last, req_ready;
   logic [8*N-1:0]   req_data;
   logic             tx_load, tx_done, locked, busy;
   logic [7:0]       tx_data;
   logic [IW-1:0]    grant_id;

   logic [1:0]       z_valid, z_last, z_ready;
   logic [15:0]      z_data;
   logic             z_load, z_done, z_locked, z_busy;
   logic [7:0]       z_txd;
   logic             z_gid;

   uart_tx_arbiter #(.NUM_REQ(N), .GAP_CLKS(G), .MAX_PKT(M)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_load(tx_load),
      .tx_data(tx_data), .tx_done(tx_done), .grant_id(grant_id),
      .locked(locked), .busy(busy));

   uart_tx_arbiter #(.NUM_REQ(2), .GAP_CLKS(0), .MAX_PKT(4)) u_dut_nogap (
      .clk(clk), .rst(rst), .req_valid(z_valid), .req_data(z_data),
      .req_last(z_last), .req_ready(z_ready), .tx_load(z_load),
      .tx_data(z_txd), .tx_done(z_done), .grant_id(z_gid),
      .locked(z_locked), .busy(z_busy));

   int          n_checks = 0;
   int          n_errors = 0;
   logic [8:0]  q [N][$];
   int          cyc, acc_cyc, free_cyc, frame_left, acc_id;
   int          m_gid, m_ptr, m_cnt;
   logic        m_locked, acc_pend, done_real, orphan, stray_en, gen_en;
   logic [7:0]  m_byte;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic all_empty();
      logic e = 1'b1;
      for (int i = 0; i < N; i++) e = e & (q[i].size() == 0);
      return e;
   endfunction

   // One clock: drive after the rising edge, predict and compare at the falling edge.
   task automatic step();
      logic         rst_prev, in_flight;
      logic [N-1:0] exp_ready, hits;
      int           tgt, id;
      rst_prev = rst;
      @(posedge clk); #1;
      cyc++;
      if (acc_pend) begin
         q[acc_id].delete(0);
         acc_pend = 1'b0;
      end
      if (tx_done) tx_done = 1'b0;
      else if (frame_left > 0) begin
         frame_left--;
         if (frame_left == 0) begin
            tx_done   = 1'b1;
            done_real = !orphan;
            orphan    = 1'b0;
         end
      end else if (stray_en && $urandom_range(15, 0) == 0) begin
         tx_done   = 1'b1;
         done_real = 1'b0;
      end
      if (gen_en && $urandom_range(7, 0) == 0) begin
         int r, len, kind;
         r    = $urandom_range(N - 1, 0);
         kind = $urandom_range(9, 0);
         len  = (kind == 0) ? 20 : $urandom_range(3, 1);
         if (q[r].size() < 24)
            for (int b = 0; b < len; b++)
               q[r].push_back({(kind != 0 && b == len - 1), 8'($urandom)});
      end
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = !rst && (q[i].size() > 0);
         req_data[8*i +: 8] = (q[i].size() > 0) ? q[i][0][7:0] : 8'h00;
         req_last[i]        = (q[i].size() > 0) ? q[i][0][8] : 1'b0;
      end

      @(negedge clk);
      if (rst_prev) begin
         m_locked = 1'b0; m_gid = 0; m_ptr = N - 1; m_cnt = 0; m_byte = 8'h00;
         acc_cyc = -1; free_cyc = 0; acc_pend = 1'b0;
         orphan = (frame_left > 0);
      end
      in_flight = (cyc > acc_cyc) && (cyc < free_cyc);
      tgt = -1;
      if (!rst && !in_flight) begin
         if (m_locked) tgt = (q[m_gid].size() > 0) ? m_gid : -1;
         else
            for (int k = 1; k <= N; k++)
               if (tgt < 0 && q[(m_ptr + k) % N].size() > 0) tgt = (m_ptr + k) % N;
      end
      exp_ready = (tgt >= 0) ? (N'(1) << tgt) : '0;
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("tx_load",   32'(tx_load),   32'(cyc == acc_cyc + 1));
      check_eq("busy",      32'(busy),      32'(in_flight || m_locked));
      check_eq("locked",    32'(locked),    32'(m_locked));
      check_eq("grant_id",  32'(grant_id),  32'(m_gid));
      check_eq("tx_data",   32'(tx_data),   32'(m_byte));

      if (tx_load) begin
         frame_left = FRAME_CLKS;
         orphan     = 1'b0;
      end
      if (tx_done && done_real) free_cyc = cyc + G + 1;

      hits = req_valid & req_ready;
      if (hits != '0) begin
         id = 0;
         for (int i = N - 1; i >= 0; i--) if (hits[i]) id = i;
         acc_pend = 1'b1;
         acc_id   = id;
         m_byte   = q[id][0][7:0];
         acc_cyc  = cyc;
         free_cyc = BIG;
         m_gid    = id;
         m_cnt++;
         if (q[id][0][8] || m_cnt == M) begin
            m_locked = 1'b0;
            m_ptr    = id;
            m_cnt    = 0;
         end else begin
            m_locked = 1'b1;
         end
      end
   endtask

   // Run until every queue is sent and the arbiter is idle; close dangling packets.
   task automatic drain(input int budget);
      int n = 0;
      while (n < budget && !(all_empty() && !m_locked && cyc >= free_cyc &&
                             frame_left == 0 && !tx_done)) begin
         if (m_locked && q[m_gid].size() == 0) q[m_gid].push_back({1'b1, 8'($urandom)});
         step();
         n++;
      end
      check_eq("drain_done", 32'(n < budget), 32'(1));
   endtask

   initial begin
      int n;
      rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
      z_valid = '0; z_data = '0; z_last = '0; z_done = 1'b0;
      cyc = 0; acc_cyc = -1; free_cyc = 0; frame_left = 0; acc_id = 0;
      m_gid = 0; m_ptr = N - 1; m_cnt = 0; m_locked = 1'b0; m_byte = 8'h00;
      acc_pend = 1'b0; done_real = 1'b0; orphan = 1'b0; stray_en = 1'b0; gen_en = 1'b0;

      repeat (3) step();
      rst = 1'b0;
      step();
      check_eq("z_reset_busy", 32'(z_busy), 32'(0));
      check_eq("z_reset_load", 32'(z_load), 32'(0));

      q[2].push_back({1'b1, 8'hAA});
      drain(400);
      for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
      drain(1000);
      q[1].push_back({1'b0, 8'h3F}); q[1].push_back({1'b0, 8'h40}); q[1].push_back({1'b1, 8'h41});
      q[0].push_back({1'b1, 8'h01}); q[2].push_back({1'b1, 8'h02});
      drain(1500);
      for (int b = 0; b < 20; b++) q[3].push_back({1'b0, 8'(8'hC0 + b)});
      q[0].push_back({1'b1, 8'h77});
      drain(4000);

      gen_en = 1'b1; stray_en = 1'b1;
      repeat (8000) step();
      gen_en = 1'b0;
      drain(25000);
      stray_en = 1'b0;

      q[1].push_back({1'b1, 8'h55});
      n = 0;
      while (!(acc_cyc >= 0 && cyc == acc_cyc + 3) && n < 50) begin step(); n++; end
      check_eq("reach_wait_done", 32'(n < 50), 32'(1));
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (FRAME_CLKS + 10) step();
      q[0].push_back({1'b1, 8'h3F});
      drain(400);

      z_valid = 2'b11; z_data = {8'h02, 8'h01}; z_last = 2'b11;
      #1;
      check_eq("z_ready_first", 32'(z_ready), 32'(2'b01));
      step();
      z_valid = 2'b10;
      check_eq("z_load_first", 32'(z_load), 32'(1));
      check_eq("z_data_first", 32'(z_txd), 32'(8'h01));
      repeat (3) step();
      check_eq("z_load_quiet", 32'(z_load), 32'(0));
      z_done = 1'b1;
      step();
      z_done = 1'b0;
      check_eq("z_busy_after_done", 32'(z_busy), 32'(0));
      check_eq("z_ready_second", 32'(z_ready), 32'(2'b10));
      step();
      z_valid = 2'b00;
      check_eq("z_load_second", 32'(z_load), 32'(1));
      check_eq("z_data_second", 32'(z_txd), 32'(8'h02));
      check_eq("z_gid_second", 32'(z_gid), 32'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #20000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
